hazard_stall_ctrl: RTL and testbench



---
 rtl/hazard_stall_ctrl_pkg.sv | 14 +
 rtl/hazard_stall_ctrl_load_use_detect.sv | 17 +
 rtl/hazard_stall_ctrl.sv | 115 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the ID-stage hazard/stall controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    HALT_DRAIN = 2'd1,
    HALTED     = 2'd2
  } hazState_t;

  localparam int         DRAIN_CYCLES_DEF = 3;
  localparam int         STALL_CNT_W_DEF  = 16;
  localparam logic [4:0] REG_ZERO         = 5'd0;

endpackage

// File: rtl/hazard_stall_ctrl_load_use_detect.sv
// Load-use hazard compare between the load in EX and the instruction in ID.
module load_use_detect
  import hazard_pkg::*;
(
  input  logic [4:0] idRs,
  input  logic [4:0] idRt,
  input  logic       idUsesRt,
  input  logic       exMemRead,
  input  logic [4:0] exRt,
  output logic       loadUse
);

  // A load into $zero never produces a value, so it cannot cause a hazard.
  assign loadUse = exMemRead && (exRt != REG_ZERO) &&
                   ((exRt == idRs) || (idUsesRt && (exRt == idRt)));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard/stall controller: load-use bubbles, branch flush, HALT drain FSM
// and debug single-step gating of the whole pipeline.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int STALL_CNT_W  = STALL_CNT_W_DEF
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_step_en,
  input  logic                   i_step,
  input  logic [4:0]             i_id_rs,
  input  logic [4:0]             i_id_rt,
  input  logic                   i_id_uses_rt,
  input  logic                   i_ex_MemRead,
  input  logic [4:0]             i_ex_rt,
  input  logic                   i_branch_taken,
  input  logic                   i_halt_dec,
  output logic                   o_ctrl_sel,
  output logic                   o_pc_write,
  output logic                   o_if_id_write,
  output logic                   o_if_id_flush,
  output logic                   o_pipe_en,
  output logic                   o_halted,
  output logic [STALL_CNT_W-1:0] o_stall_cnt
);

  localparam int                DRAIN_W    = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  hazState_t              state, stateNext;
  logic [DRAIN_W-1:0]     drainCnt, drainCntNext;
  logic [STALL_CNT_W-1:0] stallCnt, stallCntNext;
  logic                   loadUse;
  logic                   advance;

  function automatic logic [STALL_CNT_W-1:0] satInc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  endfunction

  load_use_detect uDetect (
    .idRs      (i_id_rs),
    .idRt      (i_id_rt),
    .idUsesRt  (i_id_uses_rt),
    .exMemRead (i_ex_MemRead),
    .exRt      (i_ex_rt),
    .loadUse   (loadUse)
  );

  assign advance = ~i_step_en | i_step;

  always_comb begin
    stateNext     = state;
    drainCntNext  = drainCnt;
    stallCntNext  = stallCnt;
    o_ctrl_sel    = 1'b0;
    o_pc_write    = 1'b0;
    o_if_id_write = 1'b0;
    o_if_id_flush = 1'b0;
    o_pipe_en     = 1'b0;
    o_halted      = 1'b0;
    case (state)
      RUN: begin
        o_pipe_en = advance;
        if (loadUse) begin
          // Stall beats a taken branch: its operands are not valid yet.
          if (advance) stallCntNext = satInc(stallCnt);
        end else begin
          o_ctrl_sel    = 1'b1;
          o_pc_write    = 1'b1;
          o_if_id_write = 1'b1;
          o_if_id_flush = i_branch_taken & ~i_halt_dec;
          if (i_halt_dec && advance) begin
            stateNext    = HALT_DRAIN;
            drainCntNext = '0;
          end
        end
      end
      HALT_DRAIN: begin
        o_pipe_en = advance;
        if (advance) begin
          if (drainCnt == DRAIN_LAST) stateNext = HALTED;
          else drainCntNext = drainCnt + 1'b1;
        end
      end
      HALTED: o_halted = 1'b1;
      default: stateNext = RUN;
    endcase
    // Reset holds the whole pipeline frozen with no writes.
    if (i_reset) begin
      o_ctrl_sel    = 1'b0;
      o_pc_write    = 1'b0;
      o_if_id_write = 1'b0;
      o_if_id_flush = 1'b0;
      o_pipe_en     = 1'b0;
      o_halted      = 1'b0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state    <= RUN;
      drainCnt <= '0;
      stallCnt <= '0;
    end else begin
      state    <= stateNext;
      drainCnt <= drainCntNext;
      stallCnt <= stallCntNext;
    end
  end

  assign o_stall_cnt = stallCnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl with a cycle-level behavioural model.
module tb_hazard_stall_ctrl;

  localparam int DRAIN = 3;
  localparam int CW    = 16;
  localparam int CMAX  = 65535;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, stepEn, step, usesRt, memRd, br, halt;
  logic [4:0] rs, rt, exRt;
  logic ctrlSel, pcWrite, ifIdWrite, ifIdFlush, pipeEn, halted;
  logic [CW-1:0] stallCnt;

  hazard_stall_ctrl #(.DRAIN_CYCLES(DRAIN), .STALL_CNT_W(CW)) dut (
    .i_clock(clk), .i_reset(rst), .i_step_en(stepEn), .i_step(step),
    .i_id_rs(rs), .i_id_rt(rt), .i_id_uses_rt(usesRt), .i_ex_MemRead(memRd),
    .i_ex_rt(exRt), .i_branch_taken(br), .i_halt_dec(halt),
    .o_ctrl_sel(ctrlSel), .o_pc_write(pcWrite), .o_if_id_write(ifIdWrite),
    .o_if_id_flush(ifIdFlush), .o_pipe_en(pipeEn), .o_halted(halted),
    .o_stall_cnt(stallCnt)
  );

  typedef struct packed {
    logic [5:0]    flags;  // ctrl_sel, pc_write, if_id_write, flush, pipe_en, halted
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t expQ[$];
  int nChecks = 0;
  int nPass   = 0;

  // Model: drainLeft < 0 running, > 0 draining (advancing cycles left), == 0 halted.
  int drainLeft = -1;
  int stalls    = 0;

  function automatic void check(string name, longint act, longint req);
    nChecks++;
    if (act == req) nPass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endfunction

  task automatic drive(input logic r, input logic se, input logic s,
                       input logic [4:0] iRs, input logic [4:0] iRt, input logic ur,
                       input logic mr, input logic [4:0] eRt, input logic b, input logic h);
    bit adv, lu;
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; stepEn = se; step = s; rs = iRs; rt = iRt; usesRt = ur;
    memRd = mr; exRt = eRt; br = b; halt = h;
    adv = !se || s;
    lu  = mr && eRt != 0 && (eRt == iRs || (ur && eRt == iRt));
    e.cnt = CW'((stalls > CMAX) ? CMAX : stalls);
    if (r)                  e.flags = 6'b000000;
    else if (drainLeft == 0) e.flags = 6'b000001;
    else if (drainLeft > 0)  e.flags = {4'b0000, adv, 1'b0};
    else if (lu)             e.flags = {4'b0000, adv, 1'b0};
    else                     e.flags = {3'b111, b && !h, adv, 1'b0};
    expQ.push_back(e);
    if (r) begin
      drainLeft = -1;
      stalls = 0;
    end else if (adv) begin
      if (drainLeft < 0) begin
        if (lu) stalls++;
        else if (h) drainLeft = DRAIN;
      end else if (drainLeft > 0) begin
        drainLeft--;
      end
    end
  endtask

  task automatic idle(input logic se, input logic s);
    drive(1'b0, se, s, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (expQ.size() != 0) begin
      exp_t e;
      e = expQ.pop_front();
      check("flags", {ctrlSel, pcWrite, ifIdWrite, ifIdFlush, pipeEn, halted}, e.flags);
      check("stall_cnt", stallCnt, e.cnt);
    end
  end

  initial begin
    rst = 1'b1; stepEn = 1'b0; step = 1'b0; rs = '0; rt = '0; usesRt = 1'b0;
    memRd = 1'b0; exRt = '0; br = 1'b0; halt = 1'b0;
    drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Directed: basic load-use stall then release.
    drive(0, 0, 0, 5'd5, 5'd9, 0, 1, 5'd5, 0, 0);
    idle(0, 0);
    // $zero load, store rt dependency, rt not used.
    drive(0, 0, 0, 5'd0, 5'd3, 0, 1, 5'd0, 0, 0);
    drive(0, 0, 0, 5'd1, 5'd7, 1, 1, 5'd7, 0, 0);
    drive(0, 0, 0, 5'd1, 5'd7, 0, 1, 5'd7, 0, 0);
    // Taken branch alone, then with load-use.
    drive(0, 0, 0, 5'd1, 5'd2, 0, 0, 5'd0, 1, 0);
    drive(0, 0, 0, 5'd4, 5'd2, 0, 1, 5'd4, 1, 0);
    // Halt during load-use waits; then halt drains and freezes.
    drive(0, 0, 0, 5'd4, 5'd2, 0, 1, 5'd4, 0, 1);
    drive(0, 0, 0, 5'd1, 5'd2, 0, 0, 5'd0, 1, 1);
    for (int i = 0; i < 6; i++) idle(0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Single-step drain: pulses only at drain cycles 2 and 6 (and enough to finish).
    drive(0, 0, 0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1);
    for (int i = 1; i <= 12; i++) idle(1, (i == 2 || i == 6 || i == 9));
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset in drain cycle 2 after some stalls.
    drive(0, 0, 0, 5'd6, 5'd2, 0, 1, 5'd6, 0, 0);
    drive(0, 0, 0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1);
    idle(0, 0);
    drive(1, 0, 0, 5'd6, 5'd2, 0, 1, 5'd6, 0, 0);
    idle(0, 0);
    drive(0, 0, 0, 5'd6, 5'd2, 0, 1, 5'd6, 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic r;
      r = (drainLeft == 0) ? ($urandom_range(3) == 0) : ($urandom_range(60) == 0);
      drive(r, $urandom_range(3) == 0, $urandom_range(1), 5'($urandom_range(3)),
            5'($urandom_range(3)), 1'($urandom_range(1)), $urandom_range(2) != 0,
            5'($urandom_range(3)), $urandom_range(3) == 0, $urandom_range(40) == 0);
    end

    // Saturation: more than 2^16 consecutive stalls.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65540; i++) drive(0, 0, 0, 5'd5, 5'd0, 0, 1, 5'd5, 0, 0);
    idle(0, 0);

    for (int i = 0; i < 10 && expQ.size() != 0; i++) @(negedge clk);
    check("queue_drained", expQ.size(), 0);
    @(negedge clk);
    check("stall_cnt_saturated", stallCnt, CMAX);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
